// File: rtl/wb_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : wb_stage_if
//  Purpose  : Memory-stage to write-back-stage instruction handshake bundle.
//  Revision : 1.0 - initial release
// ============================================================================
interface wb_stage_if;
    logic        ms_valid;
    logic        ms_ready;
    logic [31:0] ms_pc;
    logic [4:0]  ms_rd;
    logic        ms_gr_we;
    logic        ms_is_load;
    logic [2:0]  ms_ld_op;
    logic [1:0]  ms_addr_lo;
    logic [31:0] ms_result;

    modport master (
        output ms_valid, ms_pc, ms_rd, ms_gr_we, ms_is_load,
               ms_ld_op, ms_addr_lo, ms_result,
        input  ms_ready
    );

    modport slave (
        input  ms_valid, ms_pc, ms_rd, ms_gr_we, ms_is_load,
               ms_ld_op, ms_addr_lo, ms_result,
        output ms_ready
    );
endinterface
`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
//  Module   : wb_stage
//  Purpose  : Pipeline write-back stage: commits ALU results and aligned load
//             data to the register file and counts retired instructions.
//             Optional trace outputs enabled by macro WB_DEBUG_TRACE_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module wb_stage (
    input  wire         aclk,
    input  wire         areset,
    wb_stage_if.slave   ms,
    input  wire         data_ok,
    input  wire  [31:0] rdata,
    output logic [4:0]  rd_wb,
    output logic        reg_write_en,
    output logic [31:0] reg_write_data,
    output logic        ws_busy,
    output logic [31:0] inst_retired
`ifdef WB_DEBUG_TRACE_EN
    ,
    output logic [31:0] debug_wb_pc,
    output logic [3:0]  debug_wb_rf_we,
    output logic [4:0]  debug_wb_rf_wnum,
    output logic [31:0] debug_wb_rf_wdata
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    localparam logic [2:0] c_LD_B  = 3'd1;
    localparam logic [2:0] c_LD_H  = 3'd2;
    localparam logic [2:0] c_LD_BU = 3'd3;
    localparam logic [2:0] c_LD_HU = 3'd4;

    state_t      r_state;
    state_t      w_state_next;
    logic [4:0]  r_rd;
    logic        r_gr_we;
    logic [2:0]  r_ld_op;
    logic [1:0]  r_addr_lo;
    logic [31:0] r_result;
    logic [31:0] r_inst_retired;

    logic        w_accept;
    logic        w_load_done;
    logic        w_retire;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;

    assign w_load_done = (r_state == S_WAIT) && data_ok;
    assign ms.ms_ready = (r_state != S_WAIT) || data_ok;
    assign w_accept    = ms.ms_valid && ms.ms_ready;
    assign w_retire    = (r_state == S_HOLD) || w_load_done;
    assign ws_busy     = (r_state == S_WAIT) && !data_ok;

    always_comb begin
        w_state_next = r_state;
        if (w_accept) begin
            w_state_next = ms.ms_is_load ? S_WAIT : S_HOLD;
        end else if (r_state == S_HOLD || w_load_done) begin
            w_state_next = S_IDLE;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state   <= S_IDLE;
            r_rd      <= 5'd0;
            r_gr_we   <= 1'b0;
            r_ld_op   <= 3'd0;
            r_addr_lo <= 2'd0;
            r_result  <= 32'd0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_rd      <= ms.ms_rd;
                r_gr_we   <= ms.ms_gr_we;
                r_ld_op   <= ms.ms_ld_op;
                r_addr_lo <= ms.ms_addr_lo;
                r_result  <= ms.ms_result;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_inst_retired <= 32'd0;
        end else if (w_retire) begin
            r_inst_retired <= r_inst_retired + 32'd1;
        end
    end

    always_comb begin
        w_byte = rdata[7:0];
        case (r_addr_lo)
            2'd1:    w_byte = rdata[15:8];
            2'd2:    w_byte = rdata[23:16];
            2'd3:    w_byte = rdata[31:24];
            default: w_byte = rdata[7:0];
        endcase
        // halfword selection looks only at bit 1; bit 0 is a don't-care
        w_half = r_addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        case (r_ld_op)
            c_LD_B:  w_load_data = {{24{w_byte[7]}}, w_byte};
            c_LD_H:  w_load_data = {{16{w_half[15]}}, w_half};
            c_LD_BU: w_load_data = {24'd0, w_byte};
            c_LD_HU: w_load_data = {16'd0, w_half};
            default: w_load_data = rdata;
        endcase
    end

    always_comb begin
        reg_write_en   = w_retire && r_gr_we && (r_rd != 5'd0);
        reg_write_data = 32'd0;
        if (reg_write_en) begin
            reg_write_data = (r_state == S_HOLD) ? r_result : w_load_data;
        end
    end

    assign rd_wb        = r_rd;
    assign inst_retired = r_inst_retired;

`ifdef WB_DEBUG_TRACE_EN
    logic [31:0] r_pc;

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_pc <= 32'd0;
        end else if (w_accept) begin
            r_pc <= ms.ms_pc;
        end
    end

    assign debug_wb_pc       = r_pc;
    assign debug_wb_rf_we    = {4{reg_write_en}};
    assign debug_wb_rf_wnum  = rd_wb;
    assign debug_wb_rf_wdata = reg_write_data;
`else
    // PC is only consumed by the trace outputs
    logic w_unused_pc;
    assign w_unused_pc = ^ms.ms_pc;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_stage
//  Purpose  : Randomised scoreboard bench for wb_stage with directed corners.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wb_stage;

    logic        aclk;
    logic        areset;
    logic        data_ok;
    logic [31:0] rdata;
    logic [4:0]  rd_wb;
    logic        reg_write_en;
    logic [31:0] reg_write_data;
    logic        ws_busy;
    logic [31:0] inst_retired;
`ifdef WB_DEBUG_TRACE_EN
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_we;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;
`endif

    wb_stage_if ms_if ();

    wb_stage dut (
        .aclk           (aclk),
        .areset         (areset),
        .ms             (ms_if),
        .data_ok        (data_ok),
        .rdata          (rdata),
        .rd_wb          (rd_wb),
        .reg_write_en   (reg_write_en),
        .reg_write_data (reg_write_data),
        .ws_busy        (ws_busy),
        .inst_retired   (inst_retired)
`ifdef WB_DEBUG_TRACE_EN
        ,
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_we    (debug_wb_rf_we),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata)
`endif
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        int          cyc;
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_fail = 0;
    bit          mon_en = 1'b0;

    // reference model state
    bit          pending = 1'b0;
    bit          hold_next = 1'b0;
    logic [2:0]  p_op;
    logic [1:0]  p_addr;
    logic [4:0]  p_rd;
    bit          p_we;
    logic [31:0] m_count = 32'd0;

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Load result from the alignment rules, using arithmetic sign extension.
    function automatic logic [31:0] align(input logic [2:0] op, input logic [1:0] a,
                                          input logic [31:0] d);
        logic [31:0] b;
        logic [31:0] h;
        b = (d >> (8 * a)) & 32'hFF;
        h = (a >= 2) ? (d >> 16) : (d & 32'hFFFF);
        case (op)
            3'd1:    return (b ^ 32'h80) - 32'h80;
            3'd2:    return (h ^ 32'h8000) - 32'h8000;
            3'd3:    return b;
            3'd4:    return h;
            default: return d;
        endcase
    endfunction

    task automatic do_cycle(input bit rst, input bit valid, input bit is_load,
                            input logic [2:0] op, input logic [1:0] a, input logic [4:0] rd,
                            input bit we, input logic [31:0] res, input bit dok,
                            input logic [31:0] rd_data);
        bit hold_now;
        bit exp_ready;
        areset              = rst;
        ms_if.ms_valid      = valid;
        ms_if.ms_is_load    = is_load;
        ms_if.ms_ld_op      = op;
        ms_if.ms_addr_lo    = a;
        ms_if.ms_rd         = rd;
        ms_if.ms_gr_we      = we;
        ms_if.ms_result     = res;
        ms_if.ms_pc         = $urandom;
        data_ok             = dok;
        rdata               = rd_data;
        #2;
        hold_now  = hold_next;
        hold_next = 1'b0;
        chk("inst_retired", inst_retired, m_count);
        if (rst) begin
            pending = 1'b0;
            m_count = 32'd0;
        end else begin
            exp_ready = !pending || dok;
            chk("ms_ready", {31'd0, ms_if.ms_ready}, {31'd0, exp_ready});
            chk("ws_busy", {31'd0, ws_busy}, {31'd0, pending && !dok});
            if (hold_now || (pending && dok)) m_count = m_count + 32'd1;
            if (pending && dok) begin
                if (p_we && p_rd != 5'd0) exp_q.push_back('{cyc, p_rd, align(p_op, p_addr, rd_data)});
                pending = 1'b0;
            end
            if (valid && exp_ready) begin
                if (is_load) begin
                    pending = 1'b1;
                    p_op    = op;
                    p_addr  = a;
                    p_rd    = rd;
                    p_we    = we;
                end else begin
                    hold_next = 1'b1;
                    if (we && rd != 5'd0) exp_q.push_back('{cyc + 1, rd, res});
                end
            end
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(0, 0, 0, 3'd0, 2'd0, 5'd0, 0, 32'd0, 0, 32'd0);
    endtask

    // Monitor: pops the expected write whenever one is due this cycle.
    always @(negedge aclk) begin
        if (mon_en) begin
            bit due;
            due = (exp_q.size() > 0) && (exp_q[0].cyc <= cyc);
            chk("reg_write_en", {31'd0, reg_write_en}, {31'd0, due});
            if (due) begin
                if (reg_write_en) begin
                    chk("rd_wb", {27'd0, rd_wb}, {27'd0, exp_q[0].rd});
                    chk("reg_write_data", reg_write_data, exp_q[0].data);
                end
                void'(exp_q.pop_front());
            end else if (!reg_write_en) begin
                chk("idle_wdata", reg_write_data, 32'd0);
            end
        end
    end

    initial begin
        areset = 1'b1;
        ms_if.ms_valid = 1'b0; ms_if.ms_is_load = 1'b0; ms_if.ms_ld_op = 3'd0;
        ms_if.ms_addr_lo = 2'd0; ms_if.ms_rd = 5'd0; ms_if.ms_gr_we = 1'b0;
        ms_if.ms_result = 32'd0; ms_if.ms_pc = 32'd0; data_ok = 1'b0; rdata = 32'd0;
        repeat (3) @(posedge aclk);
        #3;
        chk("rst_ms_ready", {31'd0, ms_if.ms_ready}, 32'd1);
        chk("rst_wr_en", {31'd0, reg_write_en}, 32'd0);
        chk("rst_rd_wb", {27'd0, rd_wb}, 32'd0);
        chk("rst_wdata", reg_write_data, 32'd0);
        chk("rst_busy", {31'd0, ws_busy}, 32'd0);
        chk("rst_retired", inst_retired, 32'd0);
        mon_en = 1'b1;
        @(posedge aclk);
        #1;

        // single non-load write
        do_cycle(0, 1, 0, 3'd0, 2'd0, 5'd5, 1, 32'h12345678, 0, 32'd0);
        idle(2);
        // byte load with three wait cycles, a competing valid held off
        do_cycle(0, 1, 1, 3'd1, 2'd3, 5'd10, 1, 32'd0, 0, 32'd0);
        for (int i = 0; i < 3; i++) do_cycle(0, 1, 0, 3'd0, 2'd0, 5'd9, 1, 32'hDEAD0000, 0, 32'd0);
        do_cycle(0, 0, 0, 3'd0, 2'd0, 5'd0, 0, 32'd0, 1, 32'h80FF0000);
        // halfword loads, unsigned upper and signed lower
        do_cycle(0, 1, 1, 3'd4, 2'd2, 5'd11, 1, 32'd0, 0, 32'd0);
        do_cycle(0, 0, 0, 3'd0, 2'd0, 5'd0, 0, 32'd0, 1, 32'h8001FFFF);
        do_cycle(0, 1, 1, 3'd2, 2'd0, 5'd12, 1, 32'd0, 0, 32'd0);
        do_cycle(0, 0, 0, 3'd0, 2'd0, 5'd0, 0, 32'd0, 1, 32'h8001FFFF);
        // data_ok while idle is ignored
        do_cycle(0, 0, 0, 3'd0, 2'd0, 5'd0, 0, 32'd0, 1, 32'hFFFFFFFF);
        // back-to-back: load completes as a non-load is accepted
        do_cycle(0, 1, 1, 3'd0, 2'd1, 5'd13, 1, 32'd0, 0, 32'd0);
        do_cycle(0, 1, 0, 3'd0, 2'd0, 5'd7, 1, 32'hCAFEF00D, 1, 32'hA5A55A5A);
        idle(2);
        // rd=0 never writes but still retires; counter wraps
        do_cycle(0, 1, 0, 3'd0, 2'd0, 5'd0, 1, 32'h11111111, 0, 32'd0);
        idle(1);
        areset = 1'b0;
        #2;
        force dut.r_inst_retired = 32'hFFFFFFFF;
        #1;
        release dut.r_inst_retired;
        m_count = 32'hFFFFFFFF;
        @(posedge aclk);
        #1;
        do_cycle(0, 1, 0, 3'd0, 2'd0, 5'd0, 1, 32'h22222222, 0, 32'd0);
        idle(2);
        chk("wrapped_retired", inst_retired, 32'd0);
        // reset abandons an outstanding load and beats a same-cycle valid
        do_cycle(0, 1, 1, 3'd0, 2'd0, 5'd14, 1, 32'd0, 0, 32'd0);
        do_cycle(0, 0, 0, 3'd0, 2'd0, 5'd0, 0, 32'd0, 0, 32'd0);
        do_cycle(1, 1, 0, 3'd0, 2'd0, 5'd15, 1, 32'h33333333, 0, 32'd0);
        do_cycle(0, 0, 0, 3'd0, 2'd0, 5'd0, 0, 32'd0, 1, 32'h44444444);
        idle(2);

        for (int i = 0; i < 600; i++) begin
            bit rst_r;
            bit dok_r;
            rst_r = ($urandom_range(0, 99) == 0);
            dok_r = rst_r ? 1'b0 : ($urandom_range(0, 2) == 0);
            do_cycle(rst_r, $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                     3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                     ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
                     $urandom_range(0, 3) != 0, $urandom, dok_r, $urandom);
        end
        // finish any outstanding load, then drain
        do_cycle(0, 0, 0, 3'd0, 2'd0, 5'd0, 0, 32'd0, 1, 32'h0BADF00D);
        idle(4);
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 aclk  in  1  sole clock, all state updates on posedge.
REQ-002 areset  in  1  reset, synchronous, active-high.
REQ-003 ms_valid  in  1  memory stage presents an instruction.
REQ-004 ms_ready  out  1  wb_stage accepts the presented instruction this cycle.
REQ-005 ms_pc  in  32  PC of presented instruction.
REQ-006 ms_rd  in  5  destination GR number.
REQ-007 ms_gr_we  in  1  instruction writes a GR.
REQ-008 ms_is_load  in  1  instruction is a load awaiting memory data.
REQ-009 ms_ld_op  in  3  0=W, 1=B, 2=H, 3=BU, 4=HU; 5-7 treated as W.
REQ-010 ms_addr_lo  in  2  load address bits [1:0].
REQ-011 ms_result  in  32  ALU/CSR result for non-loads.
REQ-012 data_ok  in  1  memory read response valid; rdata  in  32  response data.
REQ-013 rd_wb  out  5, reg_write_en  out  1, reg_write_data  out  32  regfile write port; also the bypass source for the regfile read ports.
REQ-014 ws_busy  out  1  a load is waiting for data_ok.
REQ-015 inst_retired  out  32  count of committed instructions.

Function
REQ-016 FSM states: IDLE (empty), HOLD (non-load registered), WAIT (load registered, no data yet).
REQ-017 ms_ready = IDLE | HOLD | (WAIT & data_ok); accept = ms_valid & ms_ready.
REQ-018 On accept: capture pc/rd/gr_we/ld_op/addr_lo/result; next state WAIT if ms_is_load else HOLD.
REQ-019 No accept: HOLD->IDLE; WAIT->IDLE on data_ok, else stay WAIT; IDLE stays IDLE.
REQ-020 HOLD: reg_write_en = gr_we & (rd!=0); reg_write_data = captured result; one cycle only.
REQ-021 WAIT & data_ok: reg_write_en = gr_we & (rd!=0); reg_write_data = aligned rdata, combinational same cycle.
REQ-022 WAIT & !data_ok: reg_write_en=0; ws_busy=1.
REQ-023 Latency: non-load accepted at edge N drives write during cycle N+1, committed at edge N+2; load drives write in the data_ok cycle.
REQ-024 Alignment: B/BU select rdata[8*addr_lo+7:8*addr_lo]; H/HU select rdata[31:16] if addr_lo[1] else [15:0]; B/H sign-extend, BU/HU zero-extend; W passes rdata; addr_lo[0] ignored for H.
REQ-025 data_ok in IDLE or HOLD is ignored (no write, no state change).
REQ-026 WAIT & data_ok & ms_valid: the load commits and the new instruction is captured in the same cycle, no bubble.
REQ-027 rd_wb = captured rd in all states; reg_write_data = 0 when reg_write_en=0.
REQ-028 inst_retired increments by 1 in each cycle with state HOLD, or WAIT & data_ok, regardless of gr_we; wraps 0xFFFFFFFF->0.

Reset
REQ-029 areset high at posedge: state=IDLE, captured fields=0, inst_retired=0; outputs ms_ready=1, reg_write_en=0, rd_wb=0, reg_write_data=0, ws_busy=0.
REQ-030 areset in WAIT abandons the load; a later data_ok is ignored per REQ-025.
REQ-031 areset has priority over accept and data_ok in the same cycle.

Configuration
REQ-032 Macro WB_DEBUG_TRACE_EN: when defined, add outputs debug_wb_pc (32), debug_wb_rf_we (4), debug_wb_rf_wnum (5), debug_wb_rf_wdata (32), equal to captured pc, {4{reg_write_en}}, rd_wb, reg_write_data; all 0 at reset.
REQ-033 Without WB_DEBUG_TRACE_EN those ports and their logic are absent; all other behaviour is identical.

Verification
REQ-034 Non-load ms_rd=5, result=0x12345678, gr_we=1 accepted at edge N -> cycle N+1 reg_write_en=1, rd_wb=5, data=0x12345678; cycle N+2 reg_write_en=0; inst_retired=1.
REQ-035 Load ld_op=B, addr_lo=3, data_ok 3 cycles later with rdata=0x80FF0000 -> ws_busy=1 for 3 cycles, ms_ready=0 while waiting, then write data 0xFFFFFF80.
REQ-036 ld_op=HU, addr_lo=2, rdata=0x8001FFFF -> data 0x00008001; ld_op=H, addr_lo=0, same rdata -> 0xFFFFFFFF.
REQ-037 Back-to-back: WAIT & data_ok & ms_valid (non-load, rd=7) -> load writes this cycle, rd=7 writes next cycle, inst_retired +2.
REQ-038 rd=0, gr_we=1 -> reg_write_en stays 0, inst_retired still increments; preload inst_retired=0xFFFFFFFF via 2^32-1 retirements (or force) -> wraps to 0.
REQ-039 areset asserted in WAIT, then data_ok pulse -> no write, state IDLE, inst_retired=0.
